// File: rtl/mc_main_ctrl.sv
// Purpose : main control FSM of the multi-cycle RV64I-subset datapath (fetch/decode/execute/mem/wb).
// Latency : R/I 4 cycles, beq 3, ld 5, sd 4 with mem_ready high at once; each memory wait cycle adds 1.
// Backpressure: mem_ready low holds FETCH/MEMRD/MEMWR with their strobes asserted; run is sampled only at instruction boundaries.
//
// Ports:
//   clk, reset_n          clock (rising edge) and asynchronous active-low reset
//   run                   issue enable, looked at only in IDLE and at instruction boundaries
//   opcode                IR[6:0], meaningful from DECODE onward
//   mem_ready             completion of the current memory access
//   PCWrite..ALUOp        datapath enables and mux selects (ALUOp goes to alu_cu)
//   busy, illegal         status: busy outside IDLE/TRAP, illegal while trapped
// Optional feature macro: PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters (CNT_W bits wide).

module mc_main_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       busy,
    output logic       illegal
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_MEMADDR = 4'd3;
    localparam logic [3:0] S_MEMRD   = 4'd4;
    localparam logic [3:0] S_WB_MEM  = 4'd5;
    localparam logic [3:0] S_MEMWR   = 4'd6;
    localparam logic [3:0] S_EXEC_R  = 4'd7;
    localparam logic [3:0] S_EXEC_I  = 4'd8;
    localparam logic [3:0] S_WB_ALU  = 4'd9;
    localparam logic [3:0] S_BRANCH  = 4'd10;
    localparam logic [3:0] S_TRAP    = 4'd11;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [3:0] boundary_state;
    logic       at_boundary;

    // Where an instruction goes once it is finished: keep issuing only while run is high.
    assign boundary_state = run ? S_FETCH : S_IDLE;

    // High in the last cycle of every instruction (the cycle that transitions to the boundary).
    assign at_boundary = (state == S_WB_MEM) || (state == S_WB_ALU) || (state == S_BRANCH) ||
                         ((state == S_MEMWR) && mem_ready);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (run) state_nxt = S_FETCH;
            S_FETCH:   if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LD, OP_SD: state_nxt = S_MEMADDR;
                    OP_R:         state_nxt = S_EXEC_R;
                    OP_I:         state_nxt = S_EXEC_I;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    default:      state_nxt = S_TRAP;
                endcase
            end
            // Only ld and sd reach MEMADDR, so anything that is not sd is a load.
            S_MEMADDR: state_nxt = (opcode == OP_SD) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_nxt = S_WB_MEM;
            S_WB_MEM:  state_nxt = boundary_state;
            S_MEMWR:   if (mem_ready) state_nxt = boundary_state;
            S_EXEC_R:  state_nxt = S_WB_ALU;
            S_EXEC_I:  state_nxt = S_WB_ALU;
            S_WB_ALU:  state_nxt = boundary_state;
            S_BRANCH:  state_nxt = boundary_state;
            S_TRAP:    state_nxt = S_TRAP;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Moore decode; the only Mealy terms are IRWrite/PCWrite in FETCH, which follow mem_ready.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        busy        = (state != S_IDLE) && (state != S_TRAP);
        illegal     = (state == S_TRAP);
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                // PC + (imm<<1) is computed speculatively so a beq finds its target in ALUOut.
                ALUSrcB = 2'b11;
            end
            S_MEMADDR, S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_WB_ALU: begin
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef PERF_CNT_EN
    // busy is low in TRAP and no boundary is reachable from TRAP, so both counters freeze there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (busy) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (at_boundary) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_boundary;
    assign unused_boundary = at_boundary;
`endif

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: each scenario drives run/mem_ready per cycle and
// compares the full control word against hand-derived per-state values.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.

module tb_mc_main_ctrl;

    logic       clk;
    logic       reset_n;
    logic       run;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite;
    logic       IRWrite, MemtoReg, RegWrite, ALUSrcA, busy, illegal;
    logic [1:0] ALUSrcB, ALUOp;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    mc_main_ctrl #(.CNT_W(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSource    (PCSource),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .busy        (busy),
        .illegal     (illegal)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: PCWrite PCWriteCond PCSource IorD | MemRead MemWrite IRWrite MemtoReg |
    //               RegWrite ALUSrcA ALUSrcB[1:0] | ALUOp[1:0] busy illegal
    logic [15:0] outs;
    assign outs = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegWrite, ALUSrcA, ALUSrcB, ALUOp, busy, illegal};

    localparam logic [15:0] W_IDLE    = 16'h0000;
    localparam logic [15:0] W_FETCH   = 16'h8A12;  // mem_ready high
    localparam logic [15:0] W_FETCH_W = 16'h0812;  // mem_ready low
    localparam logic [15:0] W_DECODE  = 16'h0032;
    localparam logic [15:0] W_MEMADDR = 16'h0062;
    localparam logic [15:0] W_MEMRD   = 16'h1802;
    localparam logic [15:0] W_WB_MEM  = 16'h0182;
    localparam logic [15:0] W_MEMWR   = 16'h1402;
    localparam logic [15:0] W_EXEC_R  = 16'h004A;
    localparam logic [15:0] W_EXEC_I  = 16'h0062;
    localparam logic [15:0] W_WB_ALU  = 16'h0082;
    localparam logic [15:0] W_BRANCH  = 16'h6046;
    localparam logic [15:0] W_TRAP    = 16'h0001;

    task automatic drive(input logic r, input logic m);
        run       = r;
        mem_ready = m;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        run     = 1'b0;
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b0;
        opcode    = 7'b0;
        next_cycle();
        n_cmp++;
        if (outs !== W_IDLE) begin
            n_fail++;
            $display("FAIL reset_outs got=%h want=%h", outs, W_IDLE);
        end
`ifdef PERF_CNT_EN
        n_cmp++;
        if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cnt got=%0d/%0d want=0/0", cycle_cnt, instr_cnt);
        end
`endif
        #2;
        reset_n = 1'b1;
        next_cycle();
        n_cmp++;
        if (outs !== W_IDLE) begin
            n_fail++;
            $display("FAIL idle_after_reset got=%h want=%h", outs, W_IDLE);
        end
    endtask

    // Two back-to-back R-type instructions; run drops during the second one, which still completes.
    task automatic test_r_type();
        logic [15:0] ev [0:9];
        logic        rv [0:9];
        ev = '{W_IDLE, W_FETCH, W_DECODE, W_EXEC_R, W_WB_ALU,
               W_FETCH, W_DECODE, W_EXEC_R, W_WB_ALU, W_IDLE};
        rv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        opcode = 7'b0110011;
        for (int i = 0; i < 10; i++) begin
            drive(rv[i], 1'b1);
            n_cmp++;
            if (outs !== ev[i]) begin
                n_fail++;
                $display("FAIL r_type[%0d] got=%h want=%h", i, outs, ev[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_addi();
        logic [15:0] ev [0:5];
        logic        rv [0:5];
        ev = '{W_IDLE, W_FETCH, W_DECODE, W_EXEC_I, W_WB_ALU, W_IDLE};
        rv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        opcode = 7'b0010011;
        for (int i = 0; i < 6; i++) begin
            drive(rv[i], 1'b1);
            n_cmp++;
            if (outs !== ev[i]) begin
                n_fail++;
                $display("FAIL addi[%0d] got=%h want=%h", i, outs, ev[i]);
            end
            next_cycle();
        end
    endtask

    // Load with two wait cycles in MEMRD: FETCH..WB_MEM spans 7 cycles.
    task automatic test_ld_wait();
        logic [15:0] ev [0:8];
        logic        mv [0:8];
        ev = '{W_IDLE, W_FETCH, W_DECODE, W_MEMADDR, W_MEMRD, W_MEMRD, W_MEMRD, W_WB_MEM, W_IDLE};
        mv = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        opcode = 7'b0000011;
        for (int i = 0; i < 9; i++) begin
            drive(i == 0 || i == 1, mv[i]);
            n_cmp++;
            if (outs !== ev[i]) begin
                n_fail++;
                $display("FAIL ld_wait[%0d] got=%h want=%h", i, outs, ev[i]);
            end
            next_cycle();
        end
    endtask

    // Store with a fetch wait and one MEMWR wait: MemWrite high exactly two cycles, no RegWrite.
    task automatic test_sd_wait();
        logic [15:0] ev [0:7];
        logic        mv [0:7];
        ev = '{W_IDLE, W_FETCH_W, W_FETCH, W_DECODE, W_MEMADDR, W_MEMWR, W_MEMWR, W_IDLE};
        mv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 7'b0100011;
        for (int i = 0; i < 8; i++) begin
            drive(i < 2, mv[i]);
            n_cmp++;
            if (outs !== ev[i]) begin
                n_fail++;
                $display("FAIL sd_wait[%0d] got=%h want=%h", i, outs, ev[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch();
        logic [15:0] ev [0:4];
        ev = '{W_IDLE, W_FETCH, W_DECODE, W_BRANCH, W_IDLE};
        opcode = 7'b1100011;
        for (int i = 0; i < 5; i++) begin
            drive(i < 2, 1'b1);
            n_cmp++;
            if (outs !== ev[i]) begin
                n_fail++;
                $display("FAIL branch[%0d] got=%h want=%h", i, outs, ev[i]);
            end
            next_cycle();
        end
    endtask

    // Unsupported opcode traps; TRAP ignores run and mem_ready and only reset_n leaves it.
    task automatic test_trap();
        logic [15:0] ev [0:2];
        int          bad;
        ev = '{W_IDLE, W_FETCH, W_DECODE};
        opcode = 7'b1111111;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1);
            n_cmp++;
            if (outs !== ev[i]) begin
                n_fail++;
                $display("FAIL trap_entry[%0d] got=%h want=%h", i, outs, ev[i]);
            end
            next_cycle();
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, i[0]);
            if (outs !== W_TRAP) bad++;
            next_cycle();
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL trap_hold got=%0d bad cycles want=0 (last %h)", bad, outs);
        end
        run     = 1'b0;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (outs !== W_IDLE) begin
            n_fail++;
            $display("FAIL trap_reset got=%h want=%h", outs, W_IDLE);
        end
        #2;
        reset_n = 1'b1;
        next_cycle();
        n_cmp++;
        if (illegal !== 1'b0 || outs !== W_IDLE) begin
            n_fail++;
            $display("FAIL trap_exit got=%h illegal=%b want=%h illegal=0", outs, illegal, W_IDLE);
        end
    endtask

    // Reset asserted in the middle of a stalled load clears the outputs without waiting for a clock.
    task automatic test_reset_mid_access();
        logic [15:0] ev [0:4];
        ev = '{W_IDLE, W_FETCH, W_DECODE, W_MEMADDR, W_MEMRD};
        opcode = 7'b0000011;
        for (int i = 0; i < 5; i++) begin
            drive(i < 2, i == 1);
            n_cmp++;
            if (outs !== ev[i]) begin
                n_fail++;
                $display("FAIL rst_mid_setup[%0d] got=%h want=%h", i, outs, ev[i]);
            end
            if (i < 4) next_cycle();
        end
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (outs !== W_IDLE) begin
            n_fail++;
            $display("FAIL rst_mid_async got=%h want=%h", outs, W_IDLE);
        end
        #1;
        reset_n = 1'b1;
        next_cycle();
        drive(1'b0, 1'b1);
        n_cmp++;
        if (outs !== W_IDLE) begin
            n_fail++;
            $display("FAIL rst_mid_idle got=%h want=%h", outs, W_IDLE);
        end
        next_cycle();
    endtask

`ifdef PERF_CNT_EN
    // Three R-types (12 busy cycles), then a trapping opcode (2 more busy cycles) after which both freeze.
    task automatic test_perf_cnt();
        do_reset();
        opcode = 7'b0110011;
        drive(1'b1, 1'b1);
        next_cycle();
        for (int i = 0; i < 12; i++) begin
            drive(i < 11, 1'b1);
            next_cycle();
        end
        n_cmp++;
        if (instr_cnt !== 32'd3 || cycle_cnt !== 32'd12) begin
            n_fail++;
            $display("FAIL perf_r3 got=%0d/%0d want=3/12 (instr/cycle)", instr_cnt, cycle_cnt);
        end
        opcode = 7'b1111111;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1);
            next_cycle();
        end
        n_cmp++;
        if (instr_cnt !== 32'd3 || cycle_cnt !== 32'd14) begin
            n_fail++;
            $display("FAIL perf_trap_freeze got=%0d/%0d want=3/14 (instr/cycle)", instr_cnt, cycle_cnt);
        end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_r_type();
        test_addi();
        test_ld_wait();
        test_sd_wait();
        test_branch();
        test_trap();
        test_reset_mid_access();
`ifdef PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Main control FSM for the multi-cycle RV64I-subset datapath.
- Sequences fetch, decode, execute, memory and writeback over a shared ALU and a single memory port.
- Drives ALUOp into alu_cu and all datapath enables and muxes; inserts wait states on the memory handshake.
- Traps on any unsupported opcode.

Parameters:
CNT_W, 32, width of the performance counters (used only when PERF_CNT_EN is defined).

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
run  input  1  enables instruction issue; sampled only at instruction boundaries.
opcode  input  7  IR[6:0]; valid from DECODE onward.
mem_ready  input  1  memory access completes this cycle.
PCWrite  output  1  unconditional PC load.
PCWriteCond  output  1  PC load qualified by ALU Zero (beq).
PCSource  output  1  0 = ALU result, 1 = ALUOut (branch target).
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
MemRead  output  1  memory read strobe.
MemWrite  output  1  memory write strobe.
IRWrite  output  1  instruction register load.
MemtoReg  output  1  writeback select: 0 = ALUOut, 1 = MDR.
RegWrite  output  1  register file write.
ALUSrcA  output  1  0 = PC, 1 = rs1.
ALUSrcB  output  2  00 = rs2, 01 = const 4, 10 = imm, 11 = imm<<1.
ALUOp  output  2  to alu_cu: 00 add, 01 sub, 10 funct-decoded.
busy  output  1  high in every state except IDLE and TRAP.
illegal  output  1  sticky; high in TRAP.

Behaviour:
- Reset (any cycle, including mid-access) forces IDLE; all outputs 0. ALUSrcB and ALUOp are 00.
- Outputs are Moore-decoded from state, except the FETCH strobes noted below. Signals not listed for a state are 0.
- Opcodes: 0110011 R, 0010011 I (addi), 0000011 ld, 0100011 sd, 1100011 beq.
- "Boundary": the next state is FETCH if run=1, else IDLE.
- IDLE: run=1 -> FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - IRWrite and PCWrite equal mem_ready (Mealy).
  - Hold until mem_ready=1, then -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; the branch target lands in ALUOut.
  - ld/sd -> MEMADDR; R -> EXEC_R; I -> EXEC_I; beq -> BRANCH; any other opcode -> TRAP.
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. ld -> MEMRD; sd -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready, then -> WB_MEM.
- WB_MEM: RegWrite=1, MemtoReg=1 -> boundary.
- MEMWR: MemWrite=1, IorD=1. Hold until mem_ready, then -> boundary.
  - MemWrite stays asserted through all wait cycles.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> WB_ALU.
- WB_ALU: RegWrite=1, MemtoReg=0 -> boundary.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1 -> boundary.
- TRAP: illegal=1, busy=0, all strobes 0. Only reset_n exits.
- Latency with mem_ready high on the first cycle: R/I/beq 4, 3 cycles; ld 5 cycles; sd 4 cycles.
  - Each memory wait cycle adds 1.
- run deasserted mid-instruction: the instruction completes, then the FSM enters IDLE. Never abort.
- mem_ready outside FETCH/MEMRD/MEMWR: ignored.
- MemRead and MemWrite are never high together. RegWrite and PCWrite are never high together.

Optional Feature:
PERF_CNT_EN:
- Defined: adds outputs cycle_cnt[CNT_W-1:0] and instr_cnt[CNT_W-1:0], both reset to 0.
  - cycle_cnt increments every cycle busy=1.
  - instr_cnt increments on each transition into the boundary.
  - Both wrap modulo 2^CNT_W and freeze in TRAP.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- run=1, opcode=0110011, mem_ready tied 1 -> FETCH, DECODE, EXEC_R (ALUOp=10), WB_ALU (RegWrite=1); back in FETCH on cycle 5.
- ld, mem_ready low for 2 cycles in MEMRD -> MemRead=1, IorD=1 for 3 cycles; then WB_MEM with MemtoReg=1; total 7 cycles.
- sd with 1 wait cycle -> MemWrite=1 for exactly 2 cycles; RegWrite never asserts.
- beq -> BRANCH with ALUOp=01, ALUSrcB=00, PCWriteCond=1, PCSource=1 for 1 cycle.
- opcode=1111111 -> TRAP after DECODE; illegal=1 and busy=0 held for 20 cycles; reset_n low then high -> IDLE, illegal=0.
- reset_n pulsed low mid-MEMRD -> outputs 0 asynchronously; run=0 at a boundary -> IDLE. With PERF_CNT_EN: 3 R-type instructions give instr_cnt=3, cycle_cnt=12.
